// File: rtl/sensor_poll_controller.sv
// rtl/sensor_poll_controller.sv - DHT11 poll sequencer: spaced triggers, phase timeouts, checksum check, retries
module sensor_poll_controller #(
    parameter int INTERVAL = 100_000_000,
    parameter int TIMEOUT  = 5_000_000,
    parameter int RETRIES  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       req,
    output logic       dec_enable,
    output logic       dec_reset,
    input  logic       dec_hold,
    input  logic [7:0] dec_hum_int,
    input  logic [7:0] dec_hum_frac,
    input  logic [7:0] dec_temp_int,
    input  logic [7:0] dec_temp_frac,
    input  logic [7:0] dec_checksum,
    output logic [7:0] hum_int,
    output logic [7:0] hum_frac,
    output logic [7:0] temp_int,
    output logic [7:0] temp_frac,
    output logic       valid,
    output logic       fail,
    output logic       busy,
    output logic       data_ok,
    output logic [7:0] err_count
);
    localparam int GW = $clog2(INTERVAL + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic          req_pend_q, req_pend_d;
    logic          retry_pend_q, retry_pend_d;
    logic          force_fail_q, force_fail_d;
    logic          enable_q;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          fail_q, fail_d;
    logic          data_ok_q, data_ok_d;
    logic [7:0]    err_count_q, err_count_d;

    logic       gap_ready;
    logic       tmo_expired;
    logic       start;
    logic [7:0] sum;
    logic       frame_ok;

    assign gap_ready   = (gap_cnt_q == GW'(INTERVAL));
    assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign start       = retry_pend_q | req_pend_q | req | auto_en;
    assign sum         = dec_hum_int + dec_hum_frac + dec_temp_int + dec_temp_frac;
    // The decoder zeroes its frame on error, so a zero humidity byte is rejected too.
    assign frame_ok    = !force_fail_q && (sum == dec_checksum) && (dec_hum_int != 8'd0);

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_ready ? gap_cnt_q : gap_cnt_q + 1'b1;
        tmo_cnt_d    = tmo_cnt_q;
        attempt_d    = attempt_q;
        req_pend_d   = req_pend_q | req;
        retry_pend_d = retry_pend_q;
        force_fail_d = force_fail_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        fail_d       = 1'b0;
        data_ok_d    = data_ok_q;
        err_count_d  = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (gap_ready && start) begin
                    state_d    = S_TRIG;
                    req_pend_d = 1'b0;
                end
            end
            S_TRIG: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (dec_hold) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_LO;
                end else if (tmo_expired) begin
                    force_fail_d = 1'b1;
                    state_d      = S_EVAL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!dec_hold) begin
                    state_d = S_EVAL;
                end else if (tmo_expired) begin
                    force_fail_d = 1'b1;
                    state_d      = S_EVAL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                state_d      = S_IDLE;
                gap_cnt_d    = '0;
                force_fail_d = 1'b0;
                if (frame_ok) begin
                    data_d       = {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac};
                    valid_d      = 1'b1;
                    data_ok_d    = 1'b1;
                    attempt_d    = '0;
                    retry_pend_d = 1'b0;
                end else if (attempt_q < AW'(RETRIES)) begin
                    attempt_d    = attempt_q + 1'b1;
                    retry_pend_d = 1'b1;
                end else begin
                    fail_d       = 1'b1;
                    attempt_d    = '0;
                    retry_pend_d = 1'b0;
                    if (err_count_q != 8'hff) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            attempt_q    <= '0;
            req_pend_q   <= 1'b0;
            retry_pend_q <= 1'b0;
            force_fail_q <= 1'b0;
            enable_q     <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            fail_q       <= 1'b0;
            data_ok_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            attempt_q    <= attempt_d;
            req_pend_q   <= req_pend_d;
            retry_pend_q <= retry_pend_d;
            force_fail_q <= force_fail_d;
            enable_q     <= 1'b1;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fail_q       <= fail_d;
            data_ok_q    <= data_ok_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dec_enable = enable_q;
    assign dec_reset  = (state_q == S_TRIG);
    assign hum_int    = data_q[31:24];
    assign hum_frac   = data_q[23:16];
    assign temp_int   = data_q[15:8];
    assign temp_frac  = data_q[7:0];
    assign valid      = valid_q;
    assign fail       = fail_q;
    assign busy       = (state_q != S_IDLE) | req_pend_q | retry_pend_q;
    assign data_ok    = data_ok_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_sensor_poll_controller.sv
// tb/tb_sensor_poll_controller.sv - scoreboard bench for sensor_poll_controller with a behavioural DHT11 decoder
module tb_sensor_poll_controller;
    localparam int INTERVAL = 100;
    localparam int TIMEOUT  = 1000;
    localparam int RETRIES  = 2;
    localparam int KN = 0;
    localparam int KT = 1;
    localparam int KR = 2;

    typedef struct {
        bit         never;
        int         hold_len;
        logic [7:0] h, hf, ti, tf, cs;
        bit         exp_pass;
    } frame_t;

    typedef struct {
        bit         is_valid;
        logic [7:0] h, hf, ti, tf, err;
        bit         dok;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       auto_en = 1'b0;
    logic       req = 1'b0;
    logic       dec_hold = 1'b0;
    logic [7:0] dec_hum_int = '0, dec_hum_frac = '0, dec_temp_int = '0, dec_temp_frac = '0, dec_checksum = '0;
    logic       dec_enable, dec_reset, valid, fail, busy, data_ok;
    logic [7:0] hum_int, hum_frac, temp_int, temp_frac, err_count;

    sensor_poll_controller #(.INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
        .clock(clock), .reset(reset), .auto_en(auto_en), .req(req),
        .dec_enable(dec_enable), .dec_reset(dec_reset), .dec_hold(dec_hold),
        .dec_hum_int(dec_hum_int), .dec_hum_frac(dec_hum_frac),
        .dec_temp_int(dec_temp_int), .dec_temp_frac(dec_temp_frac), .dec_checksum(dec_checksum),
        .hum_int(hum_int), .hum_frac(hum_frac), .temp_int(temp_int), .temp_frac(temp_frac),
        .valid(valid), .fail(fail), .busy(busy), .data_ok(data_ok), .err_count(err_count)
    );

    always #5 clock = ~clock;

    frame_t stim_q[$];
    exp_t   exp_q[$];
    frame_t vecs[12];
    frame_t cur;
    exp_t   e;

    int n_vec = 0, n_fail = 0;
    int cyc = 0, n_trig = 0;
    int t0 = 0, fall_cyc = 0, trig_cyc = 0, last_kind = KR;
    int dm_phase = 0, dm_cnt = 0;
    int exp_d, act_d, base;

    int         m_attempt = 0;
    logic [7:0] m_err = '0, m_h = '0, m_hf = '0, m_ti = '0, m_tf = '0;
    bit         m_dok = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_frame(input frame_t f, input bit with_exp);
        stim_q.push_back(f);
        if (with_exp) begin
            if (f.exp_pass) begin
                m_attempt = 0;
                m_h = f.h; m_hf = f.hf; m_ti = f.ti; m_tf = f.tf;
                m_dok = 1'b1;
                exp_q.push_back('{1'b1, f.h, f.hf, f.ti, f.tf, m_err, 1'b1});
            end else if (m_attempt < RETRIES) begin
                m_attempt++;
            end else begin
                m_attempt = 0;
                if (m_err != 8'd255) m_err = m_err + 8'd1;
                exp_q.push_back('{1'b0, m_h, m_hf, m_ti, m_tf, m_err, m_dok});
            end
        end
    endtask

    task automatic wait_trig(input int target, input int budget, input string name);
        int b = budget;
        while (n_trig < target && b > 0) begin
            @(negedge clock);
            b--;
        end
        check(name, int'(n_trig >= target), 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int b = budget;
        while ((exp_q.size() != 0 || stim_q.size() != 0) && b > 0) begin
            @(negedge clock);
            b--;
        end
        check(name, exp_q.size() + stim_q.size(), 0);
    endtask

    task automatic pulse_req();
        @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Decoder model: hold low one cycle after the start pulse, high for hold_len cycles, frame on the fall.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            dm_phase = 0;
            dec_hold = 1'b0;
        end else if (dec_reset) begin
            case (last_kind)
                KN:      begin act_d = cyc - fall_cyc; exp_d = INTERVAL + 3; end
                KT:      begin act_d = cyc - trig_cyc; exp_d = TIMEOUT + INTERVAL + 3; end
                default: begin act_d = cyc - t0;       exp_d = INTERVAL + 1; end
            endcase
            if (auto_en) check("trig_spacing", act_d, exp_d);
            else         check("trig_spacing_min", int'(act_d >= exp_d), 1);
            check("stim_available", int'(stim_q.size() != 0), 1);
            if (stim_q.size() != 0) cur = stim_q.pop_front();
            else                    cur = '{1'b1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0};
            n_trig++;
            trig_cyc = cyc;
            dec_hold = 1'b0;
            {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum} = '0;
            last_kind = cur.never ? KT : KN;
            dm_phase  = cur.never ? 0 : 1;
        end else begin
            case (dm_phase)
                1: dm_phase = 2;
                2: begin dec_hold = 1'b1; dm_cnt = 0; dm_phase = 3; end
                3: begin
                    dm_cnt++;
                    if (dm_cnt >= cur.hold_len) begin
                        dec_hold = 1'b0;
                        {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum} =
                            {cur.h, cur.hf, cur.ti, cur.tf, cur.cs};
                        fall_cyc = cyc;
                        dm_phase = 0;
                    end
                end
                default: dm_phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clock);
        if (valid === 1'b1 || fail === 1'b1) begin
            check("pulse_exclusive", int'(valid & fail), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'({valid, fail}), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_valid", int'(valid), int'(e.is_valid));
                check("pulse_kind_fail", int'(fail), int'(!e.is_valid));
                check("hum_int", int'(hum_int), int'(e.h));
                check("hum_frac", int'(hum_frac), int'(e.hf));
                check("temp_int", int'(temp_int), int'(e.ti));
                check("temp_frac", int'(temp_frac), int'(e.tf));
                check("err_count", int'(err_count), int'(e.err));
                check("data_ok", int'(data_ok), int'(e.dok));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd79, 1'b1};
        vecs[1]  = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd80, 1'b0};
        vecs[2]  = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd80, 1'b0};
        vecs[3]  = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd80, 1'b0};
        vecs[4]  = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd80, 1'b0};
        vecs[5]  = '{1'b0, 20, 8'd60,  8'd10,  8'd22, 8'd5, 8'd97, 1'b1};
        vecs[6]  = '{1'b0, 20, 8'd200, 8'd100, 8'd10, 8'd5, 8'd59, 1'b1};
        vecs[7]  = '{1'b0, 20, 8'd0,   8'd5,   8'd20, 8'd0, 8'd25, 1'b0};
        vecs[8]  = '{1'b0, 20, 8'd0,   8'd0,   8'd0,  8'd0, 8'd0,  1'b0};
        vecs[9]  = '{1'b1, 0,  8'd0,   8'd0,   8'd0,  8'd0, 8'd0,  1'b0};
        vecs[10] = '{1'b1, 0,  8'd0,   8'd0,   8'd0,  8'd0, 8'd0,  1'b0};
        vecs[11] = '{1'b0, 20, 8'd55,  8'd0,   8'd24, 8'd0, 8'd79, 1'b1};

        repeat (3) @(negedge clock);
        check("rst_dec_enable", int'(dec_enable), 0);
        check("rst_dec_reset", int'(dec_reset), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_data_ok", int'(data_ok), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_hum_int", int'(hum_int), 0);
        check("rst_temp_int", int'(temp_int), 0);

        reset = 1'b0;
        auto_en = 1'b1;
        t0 = cyc;
        last_kind = KR;
        @(negedge clock);
        check("dec_enable_after_reset", int'(dec_enable), 1);

        for (int i = 0; i < 12; i++) begin
            base = n_trig;
            push_frame(vecs[i], 1'b1);
            wait_trig(base + 1, 3000, "vec_triggered");
        end
        wait_drain(3000, "table_drained");
        auto_en = 1'b0;
        check("table_err_count", int'(err_count), int'(m_err));

        push_frame('{1'b0, 20, 8'd30, 8'd1, 8'd20, 8'd2, 8'd53, 1'b1}, 1'b1);
        pulse_req();
        check("busy_req_pending", int'(busy), 1);
        wait_drain(1000, "req_read_done");

        push_frame('{1'b0, 20, 8'd40, 8'd0, 8'd25, 8'd0, 8'd65, 1'b1}, 1'b1);
        push_frame('{1'b0, 20, 8'd41, 8'd0, 8'd26, 8'd0, 8'd67, 1'b1}, 1'b1);
        base = n_trig;
        pulse_req();
        wait_trig(base + 1, 500, "req_b_triggered");
        repeat (3) @(negedge clock);
        pulse_req();
        repeat (3) @(negedge clock);
        pulse_req();
        wait_drain(1000, "coalesce_drained");
        check("coalesced_reads", n_trig - base, 2);
        check("busy_after_coalesce", int'(busy), 0);
        repeat (3 * INTERVAL) @(negedge clock);
        check("no_read_without_req", n_trig - base, 2);

        push_frame('{1'b0, 20, 8'd70, 8'd3, 8'd21, 8'd4, 8'd98, 1'b1}, 1'b1);
        pulse_req();
        check("req_immediate_trig", int'(dec_reset), 1);
        wait_drain(1000, "req_immediate_done");

        push_frame('{1'b0, 500, 8'd50, 8'd0, 8'd20, 8'd0, 8'd70, 1'b1}, 1'b0);
        pulse_req();
        for (int b = 0; b < 500 && dec_hold !== 1'b1; b++) @(negedge clock);
        check("hold_rose", int'(dec_hold), 1);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_valid", int'(valid), 0);
        check("midrst_fail", int'(fail), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_data_ok", int'(data_ok), 0);
        check("midrst_err_count", int'(err_count), 0);
        check("midrst_data", int'({hum_int, hum_frac, temp_int, temp_frac}), 0);
        check("midrst_dec_enable", int'(dec_enable), 0);
        check("midrst_dec_reset", int'(dec_reset), 0);
        @(negedge clock);
        reset = 1'b0;
        t0 = cyc;
        last_kind = KR;
        m_attempt = 0; m_err = '0; m_dok = 1'b0;
        m_h = '0; m_hf = '0; m_ti = '0; m_tf = '0;
        auto_en = 1'b1;
        push_frame('{1'b0, 20, 8'd55, 8'd0, 8'd24, 8'd0, 8'd79, 1'b1}, 1'b1);
        wait_drain(1000, "post_reset_read_done");
        auto_en = 1'b0;
        check("post_reset_data_ok", int'(data_ok), 1);
        check("post_reset_err_count", int'(err_count), 0);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_poll_controller.md
# sensor_poll_controller

Sequencer for the DHT11 decoder block. It decides when a sensor transaction starts, kicks the decoder, and waits for completion or timeout. It then validates the 40-bit frame by checksum, retries failed reads, and publishes a latched, validated reading to downstream consumers (display/UART). It enforces the sensor's minimum spacing between transactions on every path, including retries.

## Interface
- INTERVAL, 100_000_000: minimum cycles between the end of one transaction and the next trigger (2 s at 50 MHz); also the power-up delay before the first read.
- TIMEOUT, 5_000_000: maximum cycles per transaction phase (trigger to hold-high, hold-high to hold-low).
- RETRIES, 3: extra attempts after a failed read before reporting failure.

- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- auto_en  in  1  level; start periodic polling whenever the interval has elapsed.
- req  in  1  one-cycle single-shot read request; coalesced, at most one pending.
- dec_enable  out  1  decoder enable.
- dec_reset  out  1  one-cycle decoder start pulse.
- dec_hold  in  1  decoder busy.
- dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum  in  8 each  decoder frame bytes.
- hum_int, hum_frac, temp_int, temp_frac  out  8 each  last validated reading.
- valid  out  1  one-cycle pulse; new validated reading latched.
- fail  out  1  one-cycle pulse; all attempts exhausted.
- busy  out  1  transaction in progress, or a request/retry pending.
- data_ok  out  1  sticky; at least one valid reading since reset.
- err_count  out  8  saturating count of fail pulses.

## Operation
- States:
  - IDLE: waiting for a start condition.
  - TRIG: drive dec_reset=1 for exactly one cycle, clear the timeout counter, go to WAIT_HI.
  - WAIT_HI: on dec_hold=1 go to WAIT_LO; on timeout go to EVAL with failure forced.
  - WAIT_LO: on dec_hold=0 go to EVAL; on timeout go to EVAL with failure forced.
  - EVAL: decide pass/fail for one cycle, then return to IDLE.
- gap_cnt counts up and saturates at INTERVAL. It is cleared on reset and on every exit from EVAL. gap_ready = (gap_cnt == INTERVAL).
- IDLE to TRIG when gap_ready and any of retry_pend, req_pend, req, or auto_en is set.
  - Entering TRIG clears req_pend.
  - req arriving in any other state, or before gap_ready, sets req_pend.
- Pass in EVAL requires both:
  - (dec_hum_int + dec_hum_frac + dec_temp_int + dec_temp_frac) mod 256 == dec_checksum.
  - dec_hum_int != 0.
- The decoder zeroes its frame on its error path. An all-zero frame therefore counts as a failure. dec_error is not used.
- On pass:
  - Latch the four data bytes.
  - Pulse valid, set data_ok.
  - Clear the attempt counter and retry_pend.
- On fail with attempt < RETRIES: increment attempt, set retry_pend. The retry still waits for gap_ready and is taken even if auto_en=0.
- On fail with attempt == RETRIES: pulse fail, increment err_count (saturating at 255), clear attempt and retry_pend. Previously latched data is kept.
- dec_enable is 0 during the reset cycle and 1 on every cycle after it.
- busy = (state != IDLE) | req_pend | retry_pend.

## Timing
- Reset values:
  - State IDLE.
  - All data outputs 0.
  - valid, fail, busy, data_ok, dec_reset, dec_enable all 0.
  - err_count 0, attempt 0, both pendings 0, gap_cnt 0.
- The first trigger is possible INTERVAL cycles after reset is released.
- req sampled in IDLE with gap_ready at edge N: state is TRIG after edge N, and dec_reset is high for that cycle.
- dec_hold first sampled 0 in WAIT_LO at edge M: EVAL after M; valid/fail and latched data are registered at edge M+1. They are visible one cycle later, the same cycle gap_cnt restarts from 0.
- The decoder lowers hold in the cycle after dec_reset and raises it one cycle later. WAIT_HI therefore sees hold=1 two cycles after TRIG.
- A timeout fires when the phase counter reaches TIMEOUT-1 without the awaited edge.
- reset asserted mid-transaction returns all state to reset values on the next edge. Any pending requests are discarded.
- req coincident with a pass/fail EVAL cycle sets req_pend; it is served after the next gap.

## Test plan
Bench parameters: INTERVAL=100, TIMEOUT=1000, RETRIES=2, driven by a behavioural decoder model.
- Good frame 55,0,24,0,79 with auto_en=1: dec_reset at cycle 100 after reset; valid pulse; hum_int=55, temp_int=24; data_ok=1; next trigger exactly 100 cycles after EVAL.
- Bad checksum (55,0,24,0,80) three times: two retries each spaced 100 cycles; then one fail pulse; err_count=1; outputs keep prior values.
- Bad checksum once, then good frame: one retry; valid on the 2nd attempt; err_count unchanged; attempt counter cleared.
- dec_hold never rises: timeout after 1000 cycles in WAIT_HI; treated as failure; retry sequence proceeds.
- auto_en=0 with req pulses: one read per req; two reqs during busy coalesce into one extra read; no reads without req.
- reset asserted in WAIT_LO: all outputs return to 0 next cycle; no valid/fail pulse; first new trigger 100 cycles after reset release.
